// File: rtl/radiation_pkg.sv
`default_nettype none
//==============================================================================
// Package  : radiation_pkg
// Brief    : Shared packet framing constants, FSM state type and header builder.
// Revision : 1.0
//==============================================================================
package radiation_pkg;

   localparam int MAGIC_W = 16;
   localparam int SEQ_W   = 8;
   localparam int LEN_W   = 8;
   localparam int HDR_W   = MAGIC_W + SEQ_W + LEN_W;

   localparam logic [MAGIC_W-1:0] PKT_MAGIC = 16'hD5A5;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      HEADER  = 2'd1,
      PAYLOAD = 2'd2,
      TRAILER = 2'd3
   } pkt_state_t;

   function automatic logic [HDR_W-1:0] make_header(input logic [SEQ_W-1:0] seq,
                                                    input logic [LEN_W-1:0] len);
      return {PKT_MAGIC, seq, len};
   endfunction

endpackage
`default_nettype wire

// File: rtl/event_fifo.sv
`default_nettype none
//==============================================================================
// Module   : event_fifo
// Brief    : Synchronous FIFO with occupancy count; read data is the head entry
//            presented combinationally (no output register).
// Revision : 1.0
//==============================================================================
module event_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   i_push,
   input  logic [WIDTH-1:0]       i_wdata,
   input  logic                   i_pop,
   output logic [WIDTH-1:0]       o_rdata,
   output logic                   o_full,
   output logic                   o_empty,
   output logic [$clog2(DEPTH):0] o_level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_level;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_full    = (r_level == (AW+1)'(DEPTH));
   assign o_empty   = (r_level == '0);
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;
   assign o_rdata   = r_mem[r_rd_ptr];
   assign o_level   = r_level;

   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_wdata;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/event_stream_packetizer.sv
`default_nettype none
//==============================================================================
// Module   : event_stream_packetizer
// Brief    : Buffers AXI-Stream event words and emits framed packets
//            (header + up to PKT_LEN events); optional trailer word when the
//            PKT_TRAILER_EN macro is defined.
// Revision : 1.0
//==============================================================================
module event_stream_packetizer #(
   parameter int DATA_WIDTH     = 32,
   parameter int FIFO_DEPTH     = 16,
   parameter int PKT_LEN        = 8,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         enable,
   input  logic                         flush,
   input  logic [DATA_WIDTH-1:0]        s_axis_tdata,
   input  logic                         s_axis_tvalid,
   output logic                         s_axis_tready,
   output logic [DATA_WIDTH-1:0]        m_axis_tdata,
   output logic                         m_axis_tvalid,
   input  logic                         m_axis_tready,
   output logic                         m_axis_tlast,
   output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
   output logic [15:0]                  pkt_count
);

   import radiation_pkg::*;

   localparam int                TMR_W   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMR_W-1:0]  TMR_MAX = TMR_W'(TIMEOUT_CYCLES);
`ifdef PKT_TRAILER_EN
   localparam logic              PAYLOAD_LAST = 1'b0;
`else
   localparam logic              PAYLOAD_LAST = 1'b1;
`endif

   pkt_state_t            r_state;
   logic [SEQ_W-1:0]      r_seq;
   logic [LEN_W-1:0]      r_left;
   logic [TMR_W-1:0]      r_timer;
   logic                  r_flush_pending;

   logic [DATA_WIDTH-1:0] w_fifo_rdata;
   logic                  w_fifo_full;
   logic                  w_fifo_empty;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_accept;
   logic                  w_start;
   logic [LEN_W-1:0]      w_len;

   assign s_axis_tready = !w_fifo_full;
   assign w_push        = s_axis_tvalid && !w_fifo_full;
   assign w_accept      = m_axis_tvalid && m_axis_tready;
   // r_left counts payload words not yet loaded into the output register.
   assign w_pop   = w_accept && ((r_state == HEADER) || ((r_state == PAYLOAD) && (r_left != '0)));
   assign w_len   = (int'(fifo_level) >= PKT_LEN) ? LEN_W'(PKT_LEN) : LEN_W'(fifo_level);
   assign w_start = enable && !w_fifo_empty &&
                    ((int'(fifo_level) >= PKT_LEN) || (r_timer == TMR_MAX) || r_flush_pending);

   event_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_WIDTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_wdata (s_axis_tdata),
      .i_pop   (w_pop),
      .o_rdata (w_fifo_rdata),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty),
      .o_level (fifo_level)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state         <= IDLE;
         r_seq           <= '0;
         r_left          <= '0;
         r_timer         <= '0;
         r_flush_pending <= 1'b0;
         m_axis_tvalid   <= 1'b0;
         m_axis_tlast    <= 1'b0;
         m_axis_tdata    <= '0;
         pkt_count       <= '0;
      end else begin
         if (flush)        r_flush_pending <= 1'b1;
         if (w_fifo_empty) r_timer         <= '0;

         case (r_state)
            IDLE: begin
               if (w_start) begin
                  r_state         <= HEADER;
                  r_left          <= w_len;
                  r_timer         <= '0;
                  r_flush_pending <= 1'b0;
                  m_axis_tvalid   <= 1'b1;
                  m_axis_tlast    <= 1'b0;
                  m_axis_tdata    <= DATA_WIDTH'(make_header(r_seq, w_len));
               end else if (w_fifo_empty) begin
                  r_flush_pending <= 1'b0;
               end else if (r_timer != TMR_MAX) begin
                  r_timer <= r_timer + 1'b1;
               end
            end

            HEADER: begin
               if (w_accept) begin
                  r_state      <= PAYLOAD;
                  r_seq        <= r_seq + 1'b1;
                  r_left       <= r_left - 1'b1;
                  m_axis_tdata <= w_fifo_rdata;
                  m_axis_tlast <= PAYLOAD_LAST && (r_left == LEN_W'(1));
               end
            end

            PAYLOAD: begin
               if (w_accept) begin
                  if (r_left != '0) begin
                     r_left       <= r_left - 1'b1;
                     m_axis_tdata <= w_fifo_rdata;
                     m_axis_tlast <= PAYLOAD_LAST && (r_left == LEN_W'(1));
                  end else begin
`ifdef PKT_TRAILER_EN
                     r_state      <= TRAILER;
                     m_axis_tdata <= DATA_WIDTH'({pkt_count, 16'(fifo_level)});
                     m_axis_tlast <= 1'b1;
`else
                     r_state       <= IDLE;
                     m_axis_tvalid <= 1'b0;
                     m_axis_tlast  <= 1'b0;
                     pkt_count     <= pkt_count + 1'b1;
`endif
                  end
               end
            end

`ifdef PKT_TRAILER_EN
            TRAILER: begin
               if (w_accept) begin
                  r_state       <= IDLE;
                  m_axis_tvalid <= 1'b0;
                  m_axis_tlast  <= 1'b0;
                  pkt_count     <= pkt_count + 1'b1;
               end
            end
`endif

            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_event_stream_packetizer.sv
`default_nettype none
//==============================================================================
// Module   : tb_event_stream_packetizer
// Brief    : Scoreboard bench for event_stream_packetizer with a queue-based
//            packet model and randomized stimulus.
// Revision : 1.0
//==============================================================================
module tb_event_stream_packetizer;

   localparam int DW    = 32;
   localparam int DEPTH = 16;
   localparam int PLEN  = 8;
   localparam int TMO   = 50;
   localparam int LW    = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [31:0] data;
      logic [31:0] mask;
      logic        last;
   } beat_t;

   logic          clk           = 1'b0;
   logic          rst_n         = 1'b0;
   logic          enable        = 1'b0;
   logic          flush         = 1'b0;
   logic [DW-1:0] s_axis_tdata  = '0;
   logic          s_axis_tvalid = 1'b0;
   logic          s_axis_tready;
   logic [DW-1:0] m_axis_tdata;
   logic          m_axis_tvalid;
   logic          m_axis_tready = 1'b0;
   logic          m_axis_tlast;
   logic [LW-1:0] fifo_level;
   logic [15:0]   pkt_count;

   int          n_checks   = 0;
   int          n_fail     = 0;
   beat_t       exp_q[$];
   logic [31:0] model_q[$];
   logic [7:0]  m_seq      = 8'd0;
   int          model_pkts = 0;
   bit          rdy_random = 1'b0;
   logic        rdy_set    = 1'b0;
   bit          stalled    = 1'b0;
   logic [31:0] stall_data = '0;
   logic        stall_last = 1'b0;
   beat_t       mon_e;

   event_stream_packetizer #(
      .DATA_WIDTH     (DW),
      .FIFO_DEPTH     (DEPTH),
      .PKT_LEN        (PLEN),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .enable        (enable),
      .flush         (flush),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast),
      .fifo_level    (fifo_level),
      .pkt_count     (pkt_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      m_axis_tready = rdy_random ? 1'($urandom_range(0, 1)) : rdy_set;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Output monitor: beats are judged just before the edge that accepts them.
   always @(negedge clk) begin
      if (!rst_n) begin
         stalled = 1'b0;
      end else begin
         if (stalled) begin
            check("stall_valid", 32'(m_axis_tvalid), 32'd1);
            check("stall_data", m_axis_tdata, stall_data);
            check("stall_last", 32'(m_axis_tlast), 32'(stall_last));
         end
         if (m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_beat: got 0x%08h expected no beat at %0t", m_axis_tdata, $time);
            end else begin
               mon_e = exp_q.pop_front();
               check("beat_data", m_axis_tdata & mon_e.mask, mon_e.data & mon_e.mask);
               check("beat_last", 32'(m_axis_tlast), 32'(mon_e.last));
            end
         end
         stalled    = m_axis_tvalid && !m_axis_tready;
         stall_data = m_axis_tdata;
         stall_last = m_axis_tlast;
      end
   end

   // Build the expected packet from the oldest n words of the model queue.
   task automatic expect_packet(input int n);
      beat_t b;
      b.data = {16'hD5A5, m_seq, 8'(n)};
      b.mask = '1;
      b.last = 1'b0;
      exp_q.push_back(b);
      m_seq = m_seq + 8'd1;
      for (int i = 0; i < n; i++) begin
         b.data = model_q.pop_front();
         b.mask = '1;
`ifdef PKT_TRAILER_EN
         b.last = 1'b0;
`else
         b.last = (i == n - 1);
`endif
         exp_q.push_back(b);
      end
`ifdef PKT_TRAILER_EN
      b.data = {16'(model_pkts), 16'h0000};
      b.mask = 32'hFFFF_0000;
      b.last = 1'b1;
      exp_q.push_back(b);
`endif
      model_pkts++;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_word(input logic [31:0] d);
      bit done = 1'b0;
      s_axis_tdata  = d;
      s_axis_tvalid = 1'b1;
      for (int t = 0; t < 3000 && !done; t++) begin
         @(negedge clk);
         done = s_axis_tready;
         @(posedge clk);
         #1;
      end
      s_axis_tvalid = 1'b0;
      if (!done) begin
         n_checks++;
         n_fail++;
         $display("FAIL push_timeout: word 0x%08h not accepted, expected acceptance", d);
      end
   endtask

   task automatic pulse_flush();
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
   endtask

   task automatic wait_drain(input int bound, input string name);
      int t = 0;
      while (exp_q.size() != 0 && t < bound) begin
         @(posedge clk);
         t++;
      end
      check(name, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      wait_cycles(3);
   endtask

   task automatic model_reset();
      exp_q.delete();
      model_q.delete();
      m_seq      = 8'd0;
      model_pkts = 0;
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] w[8];
      int          n;
      bit          seen;

      enable  = 1'b1;
      rdy_set = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
      check("rst_tdata", m_axis_tdata, 32'd0);
      check("rst_tlast", 32'(m_axis_tlast), 32'd0);
      check("rst_level", 32'(fifo_level), 32'd0);
      check("rst_pkt_count", 32'(pkt_count), 32'd0);
      rst_n = 1'b1;
      wait_cycles(2);
      check("rst_s_tready", 32'(s_axis_tready), 32'd1);

      // Full packet of 8 sequential events
      for (int i = 1; i <= 8; i++) model_q.push_back(32'(i));
      expect_packet(8);
      for (int i = 1; i <= 8; i++) push_word(32'(i));
      wait_drain(100, "t1_drain");
      check("t1_pkt_count", 32'(pkt_count), 32'd1);

      // Partial packet released by the idle timeout
      for (int i = 0; i < 3; i++) model_q.push_back(32'hA1 + 32'(i));
      expect_packet(3);
      for (int i = 0; i < 3; i++) push_word(32'hA1 + 32'(i));
      wait_cycles(40);
      check("timeout_early", 32'(m_axis_tvalid), 32'd0);
      wait_drain(200, "t2_drain");

      // Partial packet released by flush
      for (int i = 0; i < 3; i++) model_q.push_back(32'hB1 + 32'(i));
      expect_packet(3);
      for (int i = 0; i < 3; i++) push_word(32'hB1 + 32'(i));
      pulse_flush();
      seen = 1'b0;
      for (int t = 0; t < 4 && !seen; t++) begin
         @(negedge clk);
         seen = m_axis_tvalid;
      end
      check("flush_latency", 32'(seen), 32'd1);
      wait_drain(100, "t3_drain");

      // Disabled: FIFO fills but no packet starts
      enable = 1'b0;
      for (int i = 0; i < 8; i++) model_q.push_back(32'hC0 + 32'(i));
      expect_packet(8);
      for (int i = 0; i < 8; i++) push_word(32'hC0 + 32'(i));
      wait_cycles(10);
      check("disabled_hold", 32'(m_axis_tvalid), 32'd0);
      check("disabled_level", 32'(fifo_level), 32'd8);
      enable = 1'b1;
      wait_drain(100, "t3b_drain");
      check("t3b_pkt_count", 32'(pkt_count), 32'd4);

      // Reset in the middle of a payload
      rdy_set = 1'b0;
      wait_cycles(2);
      for (int i = 0; i < 8; i++) model_q.push_back(32'hE0 + 32'(i));
      expect_packet(8);
      for (int i = 0; i < 8; i++) push_word(32'hE0 + 32'(i));
      wait_cycles(3);
      rdy_set = 1'b1;
      wait_cycles(3);
      rdy_set = 1'b0;
      wait_cycles(3);
      check("t4_midpkt", 32'(m_axis_tvalid), 32'd1);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("t4_tvalid", 32'(m_axis_tvalid), 32'd0);
      check("t4_tlast", 32'(m_axis_tlast), 32'd0);
      check("t4_tdata", m_axis_tdata, 32'd0);
      check("t4_level", 32'(fifo_level), 32'd0);
      check("t4_pkt_count", 32'(pkt_count), 32'd0);
      model_reset();
      wait_cycles(2);
      rst_n = 1'b1;
      wait_cycles(2);

      // Back-pressure: fill the FIFO, then release
      for (int i = 0; i < 20; i++) model_q.push_back(32'h100 + 32'(i));
      expect_packet(8);
      expect_packet(8);
      expect_packet(4);
      for (int i = 0; i < 16; i++) begin
         if (i == 15) begin
            check("t5_level15", 32'(fifo_level), 32'd15);
            check("t5_ready15", 32'(s_axis_tready), 32'd1);
         end
         push_word(32'h100 + 32'(i));
      end
      wait_cycles(1);
      check("t5_level16", 32'(fifo_level), 32'd16);
      check("t5_ready16", 32'(s_axis_tready), 32'd0);
      check("t5_header", m_axis_tdata, 32'hD5A5_0008);
      fork
         for (int i = 16; i < 20; i++) push_word(32'h100 + 32'(i));
         begin
            wait_cycles(5);
            rdy_set = 1'b1;
         end
      join
      wait_drain(600, "t5_drain");
      check("t5_pkt_count", 32'(pkt_count), 32'd3);

      // Randomized packets with random back-pressure
      rst_n = 1'b0;
      model_reset();
      wait_cycles(2);
      rst_n = 1'b1;
      wait_cycles(2);
      rdy_random = 1'b1;
      for (int p = 0; p < 300; p++) begin
         n = $urandom_range(1, 8);
         for (int i = 0; i < n; i++) begin
            w[i] = $urandom;
            model_q.push_back(w[i]);
         end
         expect_packet(n);
         for (int i = 0; i < n; i++) begin
            wait_cycles($urandom_range(0, 2));
            push_word(w[i]);
         end
         if (n < 8 && $urandom_range(0, 7) != 0) pulse_flush();
         wait_drain(1500, "t6_drain");
      end
      rdy_random = 1'b0;
      wait_cycles(2);
      check("t6_pkt_count", 32'(pkt_count), 32'd300);
      check("t6_level", 32'(fifo_level), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
